// File: rtl/fm_buf_pkg.sv
// Shared types and helpers for the layer feature-map buffer.
// Provides the FSM state encoding, a clog2 helper and the default sample width.
package fm_buf_pkg;

    localparam int FM_DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2,
        READ  = 2'd3
    } fm_state_e;

    // Address width helper; never returns less than 1 bit.
    function automatic int fm_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/layer_fm_buffer_if.sv
// Capture/replay bus of the feature-map buffer.
// master: frame source + replay sink; slave: the buffer itself.
interface layer_fm_buffer_if
    import fm_buf_pkg::*;
#(
    parameter int CH_NUM = 16,
    parameter int DATA_W = FM_DATA_W_DEF
) ();

    logic                     fm_wea;
    logic                     start_output;
    logic                     pre_vsync;
    logic                     pre_href;
    logic [CH_NUM*DATA_W-1:0] pre_data;
    logic                     save_fm_acmp;
    logic                     end_output;
    logic                     post_vsync;
    logic                     post_href;
    logic [CH_NUM*DATA_W-1:0] post_data;
    logic                     fm_busy;
    logic                     wr_overflow;

    modport master (
        output fm_wea, start_output, pre_vsync, pre_href, pre_data,
        input  save_fm_acmp, end_output, post_vsync, post_href,
        input  post_data, fm_busy, wr_overflow
    );

    modport slave (
        input  fm_wea, start_output, pre_vsync, pre_href, pre_data,
        output save_fm_acmp, end_output, post_vsync, post_href,
        output post_data, fm_busy, wr_overflow
    );

endinterface

// File: rtl/fm_channel_ram.sv
// One channel of feature-map storage: simple dual-port RAM, DEPTH x DATA_W.
// Ports: write (we/waddr/wdata), registered read (re/raddr -> rdata next cycle).
module fm_channel_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/layer_fm_buffer.sv
// Multi-channel feature-map store-and-forward buffer: captures one frame,
// replays it as a vsync/href raster with H_GAP idle cycles between rows.
// Ports: clk, rst_n (async active-low), bus (layer_fm_buffer_if.slave).
// Optional macro FM_BUF_RELU_EN: clamp negative samples to 0 on replay.
module layer_fm_buffer
    import fm_buf_pkg::*;
#(
    parameter int FM_WIDTH  = 4,
    parameter int FM_HEIGHT = 4,
    parameter int CH_NUM    = 16,
    parameter int DATA_W    = FM_DATA_W_DEF,
    parameter int H_GAP     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    layer_fm_buffer_if.slave   bus
);

    localparam int DEPTH = FM_WIDTH * FM_HEIGHT;
    localparam int AW    = fm_clog2(DEPTH);
    localparam int COL_W = fm_clog2(FM_WIDTH);
    localparam int ROW_W = fm_clog2(FM_HEIGHT);
    localparam int GAP_W = fm_clog2(H_GAP + 1);
    localparam int VEC_W = CH_NUM * DATA_W;

    fm_state_e state_q, state_d;

    logic          vs_q;
    logic          ws;
    logic          vs_rise;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] ram_waddr;
    logic          ram_we;
    logic          save_d;
    logic          ov_set;
    logic          accept;

    logic             issuing_q;
    logic [AW-1:0]    rd_addr_q;
    logic [COL_W-1:0] rd_col_q;
    logic [ROW_W-1:0] rd_row_q;
    logic [GAP_W-1:0] gap_q;
    logic             rd_en;
    logic             col_end;
    logic             row_end;
    logic             rd_last;

    logic s1_vsync_q, s1_href_q, s1_last_q, p_last_q;

    logic             save_q, end_q, busy_q, ov_q;
    logic             post_vsync_q, post_href_q;
    logic [VEC_W-1:0] post_data_q;
    logic [VEC_W-1:0] ram_rdata;
    logic [VEC_W-1:0] out_data;

    assign ws      = bus.fm_wea & bus.pre_href;
    assign vs_rise = bus.pre_vsync & ~vs_q;

    // Control FSM: next state, write port and overflow/accept strobes.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        ram_we    = 1'b0;
        ram_waddr = wr_addr_q;
        save_d    = 1'b0;
        ov_set    = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ws) begin
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                    if (DEPTH == 1) begin
                        state_d   = FULL;
                        save_d    = 1'b1;
                        wr_addr_d = '0;
                    end else begin
                        state_d   = WRITE;
                        wr_addr_d = AW'(1);
                    end
                end
            end
            WRITE: begin
                if (vs_rise) begin
                    // New frame start: restart capture from address 0.
                    wr_addr_d = '0;
                    if (ws) begin
                        ram_we    = 1'b1;
                        ram_waddr = '0;
                        wr_addr_d = AW'(1);
                    end
                end else if (ws) begin
                    ram_we = 1'b1;
                    if (wr_addr_q == AW'(DEPTH - 1)) begin
                        state_d   = FULL;
                        save_d    = 1'b1;
                        wr_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            FULL: begin
                ov_set = ws;
                if (bus.start_output) begin
                    accept  = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                ov_set = ws;
                if (p_last_q) begin
                    state_d   = IDLE;
                    wr_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            vs_q      <= 1'b0;
            save_q    <= 1'b0;
            busy_q    <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            vs_q      <= bus.pre_vsync;
            save_q    <= save_d;
            busy_q    <= (state_d == WRITE) || (state_d == READ);
            // A same-cycle overflow wins over the clear on accept.
            if (ov_set) ov_q <= 1'b1;
            else if (accept) ov_q <= 1'b0;
        end
    end

    // Replay sequencer: one slot per cycle, either a pixel read or a gap.
    assign col_end = (rd_col_q == COL_W'(FM_WIDTH - 1));
    assign row_end = (rd_row_q == ROW_W'(FM_HEIGHT - 1));
    assign rd_en   = issuing_q && (gap_q == '0);
    assign rd_last = rd_en && col_end && row_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issuing_q <= 1'b0;
            rd_addr_q <= '0;
            rd_col_q  <= '0;
            rd_row_q  <= '0;
            gap_q     <= '0;
        end else if (accept) begin
            issuing_q <= 1'b1;
            rd_addr_q <= '0;
            rd_col_q  <= '0;
            rd_row_q  <= '0;
            gap_q     <= '0;
        end else if (issuing_q) begin
            if (rd_en) begin
                rd_addr_q <= rd_addr_q + AW'(1);
                if (col_end) begin
                    rd_col_q <= '0;
                    if (row_end) begin
                        issuing_q <= 1'b0;
                    end else begin
                        rd_row_q <= rd_row_q + ROW_W'(1);
                        gap_q    <= GAP_W'(H_GAP);
                    end
                end else begin
                    rd_col_q <= rd_col_q + COL_W'(1);
                end
            end else begin
                gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        fm_channel_ram #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we),
            .waddr (ram_waddr),
            .wdata (bus.pre_data[k*DATA_W +: DATA_W]),
            .re    (rd_en),
            .raddr (rd_addr_q),
            .rdata (ram_rdata[k*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        out_data = ram_rdata;
`ifdef FM_BUF_RELU_EN
        for (int k = 0; k < CH_NUM; k++) begin
            if (ram_rdata[k*DATA_W + DATA_W - 1]) begin
                out_data[k*DATA_W +: DATA_W] = '0;
            end
        end
`endif
    end

    // Stage 1 aligns with the RAM read, stage 2 drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vsync_q   <= 1'b0;
            s1_href_q    <= 1'b0;
            s1_last_q    <= 1'b0;
            post_vsync_q <= 1'b0;
            post_href_q  <= 1'b0;
            post_data_q  <= '0;
            p_last_q     <= 1'b0;
            end_q        <= 1'b0;
        end else begin
            s1_vsync_q   <= issuing_q;
            s1_href_q    <= rd_en;
            s1_last_q    <= rd_last;
            post_vsync_q <= s1_vsync_q;
            post_href_q  <= s1_href_q;
            post_data_q  <= s1_href_q ? out_data : '0;
            p_last_q     <= s1_last_q;
            end_q        <= p_last_q;
        end
    end

    assign bus.save_fm_acmp = save_q;
    assign bus.end_output   = end_q;
    assign bus.post_vsync   = post_vsync_q;
    assign bus.post_href    = post_href_q;
    assign bus.post_data    = post_data_q;
    assign bus.fm_busy      = busy_q;
    assign bus.wr_overflow  = ov_q;

endmodule

// File: tb/tb_layer_fm_buffer.sv
// Scoreboard bench for layer_fm_buffer: H_GAP=0 and H_GAP=2 instances
// share one stimulus stream; monitors pop expected pixels on post_href.
module tb_layer_fm_buffer;
    import fm_buf_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int CH = 16;
    localparam int DW = 16;
    localparam int DEPTH = W * H;
    localparam int VW = CH * DW;

    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic fm_wea = 1'b0;
    logic start_output = 1'b0;
    logic pre_vsync = 1'b0;
    logic pre_href = 1'b0;
    vec_t pre_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_first = 0;
    vec_t model [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    layer_fm_buffer_if #(.CH_NUM(CH), .DATA_W(DW)) bus0 ();
    layer_fm_buffer_if #(.CH_NUM(CH), .DATA_W(DW)) bus1 ();

    assign bus0.fm_wea = fm_wea;
    assign bus0.start_output = start_output;
    assign bus0.pre_vsync = pre_vsync;
    assign bus0.pre_href = pre_href;
    assign bus0.pre_data = pre_data;
    assign bus1.fm_wea = fm_wea;
    assign bus1.start_output = start_output;
    assign bus1.pre_vsync = pre_vsync;
    assign bus1.pre_href = pre_href;
    assign bus1.pre_data = pre_data;

    layer_fm_buffer #(
        .FM_WIDTH(W), .FM_HEIGHT(H), .CH_NUM(CH), .DATA_W(DW), .H_GAP(0)
    ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    layer_fm_buffer #(
        .FM_WIDTH(W), .FM_HEIGHT(H), .CH_NUM(CH), .DATA_W(DW), .H_GAP(2)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic pv [2];
    logic ph [2];
    logic eo [2];
    logic sv [2];
    vec_t pd [2];
    assign pv[0] = bus0.post_vsync;
    assign pv[1] = bus1.post_vsync;
    assign ph[0] = bus0.post_href;
    assign ph[1] = bus1.post_href;
    assign eo[0] = bus0.end_output;
    assign eo[1] = bus1.end_output;
    assign sv[0] = bus0.save_fm_acmp;
    assign sv[1] = bus1.save_fm_acmp;
    assign pd[0] = bus0.post_data;
    assign pd[1] = bus1.post_data;

    task automatic chk(input string name, input vec_t act, input vec_t expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] pix(int off, bit neg, int k, int p);
        if (neg && (k % 2 == 1)) return 16'h8001 + 16'(p);
        return 16'(k * 256 + p + off);
    endfunction

    function automatic vec_t frame_vec(int off, bit neg, int p);
        vec_t v;
        for (int k = 0; k < CH; k++) v[k*DW +: DW] = pix(off, neg, k, p);
        return v;
    endfunction

    function automatic vec_t relu_model(vec_t v);
        vec_t r;
        r = v;
`ifdef FM_BUF_RELU_EN
        for (int k = 0; k < CH; k++)
            if (v[k*DW + DW - 1]) r[k*DW +: DW] = '0;
`endif
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        localparam int G = gi * 2;
        localparam int EXP_VS = DEPTH + (H - 1) * G;
        vec_t exp_q [$];
        int vs_cnt = 0;
        int frames = 0;
        int saves = 0;
        logic prev_vs = 1'b0;
        vec_t got;

        always @(negedge clk) begin
            if (!rst_n) begin
                vs_cnt = 0;
                prev_vs = 1'b0;
            end else begin
                if (sv[gi]) saves++;
                if (pv[gi]) begin
                    if (!prev_vs) chk("first_latency", vec_t'(cyc), vec_t'(exp_first));
                    chk("href_pattern", vec_t'(ph[gi]), vec_t'((vs_cnt % (W + G)) < W));
                    vs_cnt++;
                end
                if (ph[gi]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pixel_unexpected: got %h expected none", pd[gi]);
                    end else begin
                        got = exp_q.pop_front();
                        chk("pixel_data", pd[gi], got);
                    end
                end else begin
                    chk("data_idle_zero", pd[gi], '0);
                end
                if (prev_vs && !pv[gi]) begin
                    chk("end_pulse", vec_t'(eo[gi]), vec_t'(1));
                    chk("vsync_len", vec_t'(vs_cnt), vec_t'(EXP_VS));
                    chk("queue_drained", vec_t'(exp_q.size()), '0);
                    vs_cnt = 0;
                    frames++;
                end else if (eo[gi]) begin
                    checks++;
                    errors++;
                    $display("FAIL end_spurious: got 1 expected 0");
                end
                prev_vs = pv[gi];
            end
        end
    end

    task automatic send(input int off, input bit neg, input int n);
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            if (p == DEPTH - 1) begin
                chk("busy_last_wr", vec_t'(bus0.fm_busy), vec_t'(1));
                chk("save_early", vec_t'(bus0.save_fm_acmp), '0);
            end
            pre_vsync = 1'b1;
            pre_href = 1'b1;
            fm_wea = 1'b1;
            pre_data = frame_vec(off, neg, p);
            model[p] = pre_data;
        end
        @(negedge clk);
        pre_href = 1'b0;
        fm_wea = 1'b0;
        pre_data = '0;
        if (n == DEPTH) begin
            chk("save_pulse0", vec_t'(bus0.save_fm_acmp), vec_t'(1));
            chk("save_pulse1", vec_t'(bus1.save_fm_acmp), vec_t'(1));
            chk("busy_fall", vec_t'(bus0.fm_busy), '0);
        end
    endtask

    task automatic push_model();
        for (int p = 0; p < DEPTH; p++) begin
            g_mon[0].exp_q.push_back(relu_model(model[p]));
            g_mon[1].exp_q.push_back(relu_model(model[p]));
        end
    endtask

    task automatic wait_done(input int t0, input int t1);
        int k;
        for (k = 0; k < 400; k++) begin
            if (g_mon[0].frames >= t0 && g_mon[1].frames >= t1) break;
            @(negedge clk);
        end
        chk("replay_done", vec_t'(k < 400), vec_t'(1));
    endtask

    task automatic replay(input bit ov_mid);
        int n0, n1;
        n0 = g_mon[0].frames;
        n1 = g_mon[1].frames;
        push_model();
        @(negedge clk);
        start_output = 1'b1;
        exp_first = cyc + 3;
        @(negedge clk);
        start_output = 1'b0;
        chk("ov_clear0", vec_t'(bus0.wr_overflow), '0);
        chk("ov_clear1", vec_t'(bus1.wr_overflow), '0);
        chk("busy_read", vec_t'(bus0.fm_busy), vec_t'(1));
        if (ov_mid) begin
            repeat (3) @(negedge clk);
            pre_href = 1'b1;
            fm_wea = 1'b1;
            pre_data = {CH{16'hDEAD}};
            @(negedge clk);
            pre_href = 1'b0;
            fm_wea = 1'b0;
            pre_data = '0;
            chk("ov_read0", vec_t'(bus0.wr_overflow), vec_t'(1));
            chk("ov_read1", vec_t'(bus1.wr_overflow), vec_t'(1));
        end
        wait_done(n0 + 1, n1 + 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_vsync"}, vec_t'(bus0.post_vsync), '0);
        chk({tag, "_href"}, vec_t'(bus0.post_href), '0);
        chk({tag, "_data"}, bus0.post_data, '0);
        chk({tag, "_save"}, vec_t'(bus0.save_fm_acmp), '0);
        chk({tag, "_end"}, vec_t'(bus0.end_output), '0);
        chk({tag, "_busy"}, vec_t'(bus0.fm_busy), '0);
        chk({tag, "_ov"}, vec_t'(bus0.wr_overflow), '0);
        chk({tag, "_vsync1"}, vec_t'(bus1.post_vsync), '0);
    endtask

    initial begin
        int s0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        s0 = g_mon[0].saves;
        send(0, 1'b0, DEPTH);
        pre_vsync = 1'b0;
        @(negedge clk);
        chk("save_once", vec_t'(g_mon[0].saves - s0), vec_t'(1));
        replay(1'b0);

        s0 = g_mon[0].saves;
        send('h40, 1'b0, 7);
        pre_vsync = 1'b0;
        repeat (2) @(negedge clk);
        send('h80, 1'b0, DEPTH);
        pre_vsync = 1'b0;
        @(negedge clk);
        chk("restart_save_once", vec_t'(g_mon[0].saves - s0), vec_t'(1));
        replay(1'b0);

        send('hC0, 1'b0, DEPTH);
        pre_vsync = 1'b0;
        @(negedge clk);
        pre_href = 1'b1;
        fm_wea = 1'b1;
        pre_data = {CH{16'hBEEF}};
        @(negedge clk);
        pre_href = 1'b0;
        fm_wea = 1'b0;
        pre_data = '0;
        chk("ov_full0", vec_t'(bus0.wr_overflow), vec_t'(1));
        chk("ov_full1", vec_t'(bus1.wr_overflow), vec_t'(1));
        replay(1'b1);

        send('h20, 1'b0, DEPTH);
        pre_vsync = 1'b0;
        @(negedge clk);
        chk("ov_sticky", vec_t'(bus0.wr_overflow), vec_t'(1));
        replay(1'b0);

        send('h30, 1'b0, DEPTH);
        pre_vsync = 1'b0;
        push_model();
        @(negedge clk);
        start_output = 1'b1;
        exp_first = cyc + 3;
        @(negedge clk);
        start_output = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        g_mon[0].exp_q.delete();
        g_mon[1].exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        send(0, 1'b1, DEPTH);
        pre_vsync = 1'b0;
        replay(1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
